// File: rtl/img_rsz_blk_comp.sv
// img_rsz_blk_comp: reads a block sum and divides it by BLK_PXL_NUM with a bit-serial restoring divider.
// Define IMG_RSZ_COMP_ROUND_EN to round to nearest instead of floor.
module img_rsz_blk_comp #(
    parameter int RSZ_IMG_WIDTH_SIZE   = 8,
    parameter int RSZ_IMG_HEIGHT_SIZE  = 8,
    parameter int RSZ_IMG_WIDTH_IDX_W  = $clog2(RSZ_IMG_WIDTH_SIZE),
    parameter int RSZ_IMG_HEIGHT_IDX_W = $clog2(RSZ_IMG_HEIGHT_SIZE),
    parameter int PXL_W                = 8,
    parameter int BLK_PXL_NUM          = 16,
    parameter int SUM_W                = PXL_W + $clog2(BLK_PXL_NUM)
) (
    input  logic                            Clk,
    input  logic                            Reset,
    input  logic [RSZ_IMG_WIDTH_IDX_W-1:0]  CompBlkXIdx,
    input  logic [RSZ_IMG_HEIGHT_IDX_W-1:0] CompBlkYIdx,
    input  logic                            CompBlkVld,
    output logic                            CompBlkRdy,
    output logic                            SumRdEn,
    output logic [RSZ_IMG_WIDTH_IDX_W-1:0]  SumRdXIdx,
    output logic [RSZ_IMG_HEIGHT_IDX_W-1:0] SumRdYIdx,
    input  logic [SUM_W-1:0]                SumRdData,
    output logic [PXL_W-1:0]                RszPxlData,
    output logic [RSZ_IMG_WIDTH_IDX_W-1:0]  RszPxlXIdx,
    output logic [RSZ_IMG_HEIGHT_IDX_W-1:0] RszPxlYIdx,
    output logic                            RszPxlVld,
    input  logic                            RszPxlRdy
);
    localparam int DIV_W = SUM_W + 1;
    localparam int CNT_W = $clog2(DIV_W + 1);
    localparam logic [DIV_W:0] DVS = (DIV_W + 1)'(BLK_PXL_NUM);

    typedef enum logic [1:0] {IDLE, LOAD, DIV, OUT} state_t;

    state_t                          r_state, w_next;
    logic [RSZ_IMG_WIDTH_IDX_W-1:0]  r_x;
    logic [RSZ_IMG_HEIGHT_IDX_W-1:0] r_y;
    logic [DIV_W-1:0]                r_dvd, r_rem, w_rem_nxt, w_quo_nxt, w_ld;
    logic [DIV_W-2:0]                r_quo;
    logic [CNT_W-1:0]                r_cnt;
    logic [PXL_W-1:0]                r_pxl, w_pxl;
    logic [DIV_W:0]                  w_shift;
    logic                            r_vld, w_hs, w_ge, w_last;

    assign CompBlkRdy = (r_state == IDLE) & Reset;
    assign w_hs       = CompBlkVld & CompBlkRdy;
    assign SumRdEn    = w_hs;
    assign SumRdXIdx  = CompBlkXIdx;
    assign SumRdYIdx  = CompBlkYIdx;
    assign RszPxlData = r_pxl;
    assign RszPxlXIdx = r_x;
    assign RszPxlYIdx = r_y;
    assign RszPxlVld  = r_vld;

`ifdef IMG_RSZ_COMP_ROUND_EN
    assign w_ld = {1'b0, SumRdData} + DIV_W'(BLK_PXL_NUM >> 1);
`else
    assign w_ld = {1'b0, SumRdData};
`endif

    assign w_shift   = {r_rem, r_dvd[DIV_W-1]};
    assign w_ge      = w_shift >= DVS;
    assign w_rem_nxt = DIV_W'(w_ge ? w_shift - DVS : w_shift);
    assign w_quo_nxt = {r_quo, w_ge};
    assign w_last    = r_cnt == CNT_W'(DIV_W - 1);
    // Any quotient bit above the pixel width means the sum exceeded the nominal maximum.
    assign w_pxl     = |w_quo_nxt[DIV_W-1:PXL_W] ? '1 : w_quo_nxt[PXL_W-1:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_hs ? LOAD : IDLE;
            LOAD:    w_next = DIV;
            DIV:     w_next = w_last ? OUT : DIV;
            OUT:     w_next = RszPxlRdy ? IDLE : OUT;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_dvd   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_pxl   <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        r_x <= CompBlkXIdx;
                        r_y <= CompBlkYIdx;
                    end
                end
                LOAD: begin
                    r_dvd <= w_ld;
                    r_rem <= '0;
                    r_quo <= '0;
                    r_cnt <= '0;
                end
                DIV: begin
                    r_dvd <= {r_dvd[DIV_W-2:0], 1'b0};
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt[DIV_W-2:0];
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_pxl <= w_pxl;
                        r_vld <= 1'b1;
                    end
                end
                OUT: begin
                    if (RszPxlRdy) r_vld <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_img_rsz_blk_comp.sv
// tb_img_rsz_blk_comp: randomized self-checking bench for img_rsz_blk_comp against an arithmetic model.
module tb_img_rsz_blk_comp;
    localparam int XW  = 3;
    localparam int YW  = 3;
    localparam int PW  = 8;
    localparam int BLK = 16;
    localparam int SW  = 12;
    localparam int LAT = SW + 3;

    logic          Clk = 1'b0;
    logic          Reset = 1'b0;
    logic [XW-1:0] CompBlkXIdx = '0;
    logic [YW-1:0] CompBlkYIdx = '0;
    logic          CompBlkVld = 1'b0;
    logic          CompBlkRdy;
    logic          SumRdEn;
    logic [XW-1:0] SumRdXIdx;
    logic [YW-1:0] SumRdYIdx;
    logic [SW-1:0] SumRdData = '0;
    logic [PW-1:0] RszPxlData;
    logic [XW-1:0] RszPxlXIdx;
    logic [YW-1:0] RszPxlYIdx;
    logic          RszPxlVld;
    logic          RszPxlRdy = 1'b1;

    logic [SW-1:0] mem [8][8];
    int n_chk = 0;
    int n_err = 0;

    img_rsz_blk_comp dut (
        .Clk(Clk), .Reset(Reset),
        .CompBlkXIdx(CompBlkXIdx), .CompBlkYIdx(CompBlkYIdx),
        .CompBlkVld(CompBlkVld), .CompBlkRdy(CompBlkRdy),
        .SumRdEn(SumRdEn), .SumRdXIdx(SumRdXIdx), .SumRdYIdx(SumRdYIdx),
        .SumRdData(SumRdData),
        .RszPxlData(RszPxlData), .RszPxlXIdx(RszPxlXIdx), .RszPxlYIdx(RszPxlYIdx),
        .RszPxlVld(RszPxlVld), .RszPxlRdy(RszPxlRdy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) SumRdData <= SumRdEn ? mem[SumRdXIdx][SumRdYIdx] : '0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model(input int s);
        int q;
`ifdef IMG_RSZ_COMP_ROUND_EN
        q = (s + BLK / 2) / BLK;
`else
        q = s / BLK;
`endif
        return q > 255 ? 255 : q;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Entered just after a clock edge; leaves just after the edge of the output handshake.
    task automatic run_blk(input int x, input int y, input int sum, input int stall,
                           input bit arm_next, input int nx, input int ny);
        int lat;
        int exp;
        exp = model(sum);
        mem[x][y] = SW'(sum);
        CompBlkXIdx = XW'(x);
        CompBlkYIdx = YW'(y);
        CompBlkVld = 1'b1;
        RszPxlRdy = (stall == 0);
        #1;
        chk("req_rdy", int'(CompBlkRdy), 1);
        chk("rd_en", int'(SumRdEn), 1);
        chk("rd_x", int'(SumRdXIdx), x);
        chk("rd_y", int'(SumRdYIdx), y);
        lat = 0;
        do begin
            tick();
            CompBlkVld = 1'b0;
            lat++;
        end while (!RszPxlVld && lat < 100);
        chk("latency", lat, LAT);
        for (int i = 0; i < stall; i++) begin
            if (arm_next) begin
                CompBlkXIdx = XW'(nx);
                CompBlkYIdx = YW'(ny);
                CompBlkVld = 1'b1;
                #1;
            end
            chk("stall_vld", int'(RszPxlVld), 1);
            chk("stall_data", int'(RszPxlData), exp);
            chk("stall_x", int'(RszPxlXIdx), x);
            chk("stall_y", int'(RszPxlYIdx), y);
            chk("stall_rdy", int'(CompBlkRdy), 0);
            chk("stall_rden", int'(SumRdEn), 0);
            tick();
        end
        RszPxlRdy = 1'b1;
        chk("pxl_data", int'(RszPxlData), exp);
        chk("pxl_x", int'(RszPxlXIdx), x);
        chk("pxl_y", int'(RszPxlYIdx), y);
        tick();
        chk("vld_drop", int'(RszPxlVld), 0);
    endtask

    initial begin
        int t[2];
        int d[2];
        int n_out;
        int n_acc;
        int seen;
        bit acc;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                mem[i][j] = '0;
        tick();
        tick();
        chk("rst_rdy", int'(CompBlkRdy), 0);
        chk("rst_vld", int'(RszPxlVld), 0);
        chk("rst_rden", int'(SumRdEn), 0);
        chk("rst_data", int'(RszPxlData), 0);
        chk("rst_x", int'(RszPxlXIdx), 0);
        chk("rst_y", int'(RszPxlYIdx), 0);
        Reset = 1'b1;
        tick();
        chk("post_rst_rdy", int'(CompBlkRdy), 1);

        run_blk(3, 5, 1600, 0, 0, 0, 0);
        chk("rdy_back", int'(CompBlkRdy), 1);
        run_blk(2, 4, 1615, 0, 0, 0, 0);
        run_blk(6, 1, 1607, 0, 0, 0, 0);
        run_blk(0, 7, 0, 0, 0, 0, 0);
        run_blk(5, 5, 4080, 0, 0, 0, 0);
        run_blk(4, 2, 800, 6, 1, 1, 1);
        run_blk(1, 1, 1234, 0, 0, 0, 0);

        // Back-to-back: the request stays asserted and only switches index once accepted.
        mem[0][0] = 12'd16;
        mem[7][7] = 12'd32;
        CompBlkXIdx = 3'd0;
        CompBlkYIdx = 3'd0;
        CompBlkVld = 1'b1;
        RszPxlRdy = 1'b1;
        #1;
        n_out = 0;
        n_acc = 0;
        for (int c = 0; c < 80 && n_out < 2; c++) begin
            acc = CompBlkRdy & CompBlkVld;
            if (RszPxlVld) begin
                t[n_out] = c;
                d[n_out] = int'(RszPxlData);
                n_out++;
            end
            tick();
            if (acc) begin
                n_acc++;
                if (n_acc == 1) begin
                    CompBlkXIdx = 3'd7;
                    CompBlkYIdx = 3'd7;
                end else CompBlkVld = 1'b0;
            end
        end
        chk("b2b_count", n_out, 2);
        chk("b2b_first", d[0], model(16));
        chk("b2b_second", d[1], model(32));
        chk("b2b_gap", t[1] - t[0], SW + 4);
        tick();

        // Abort a transaction in the middle of division.
        mem[2][6] = 12'd3000;
        CompBlkXIdx = 3'd2;
        CompBlkYIdx = 3'd6;
        CompBlkVld = 1'b1;
        tick();
        CompBlkVld = 1'b0;
        repeat (5) tick();
        #2 Reset = 1'b0;
        #1;
        chk("abort_vld", int'(RszPxlVld), 0);
        chk("abort_rdy", int'(CompBlkRdy), 0);
        tick();
        Reset = 1'b1;
        tick();
        chk("abort_rdy_back", int'(CompBlkRdy), 1);
        seen = 0;
        repeat (20) begin
            tick();
            seen += int'(RszPxlVld);
        end
        chk("abort_no_out", seen, 0);
        run_blk(2, 6, 3000, 0, 0, 0, 0);

        for (int k = 0; k < 20; k++)
            run_blk($urandom_range(7), $urandom_range(7), $urandom_range(4095),
                    $urandom_range(3), 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
